// File: rtl/gcd_uart_reporter_pkg.sv
// Shared constants, state encodings and digit helpers for the GCD UART reporter.
// Imported by the byte serializer and the message sequencer.
package gcd_uart_reporter_pkg;

    localparam int MSG_LEN = 15;

    localparam logic [7:0] ASCII_G      = 8'h47;
    localparam logic [7:0] ASCII_C      = 8'h43;
    localparam logic [7:0] ASCII_D      = 8'h44;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;
    localparam logic [7:0] ASCII_DASH   = 8'h2D;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_SEND,
        REP_DRAIN,
        REP_FINISH
    } rep_state_t;

    // Snapshot form of an operand: anything above 99 only needs to be remembered as "out of range".
    typedef struct packed {
        logic       over;
        logic [6:0] val;
    } operand_t;

    function automatic operand_t snap_operand(input logic [31:0] v);
        operand_t op;
        op.over = (v > 32'd99);
        op.val  = op.over ? 7'd0 : v[6:0];
        return op;
    endfunction

    // Two ASCII characters {tens, ones}, zero-padded, or "--" when out of range.
    function automatic logic [15:0] to_digits(input operand_t op);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = op.val / 7'd10;
        ones = op.val - tens * 7'd10;
        if (op.over) begin
            return {ASCII_DASH, ASCII_DASH};
        end
        return {ASCII_ZERO + {1'b0, tens}, ASCII_ZERO + {1'b0, ones}};
    endfunction

endpackage

// File: rtl/gcd_uart_reporter_tx.sv
// 8N1 UART byte serializer with a valid/ready handshake.
// Accepts the next byte in the last stop-bit cycle so consecutive frames have no idle gap.
module uart_tx_byte
    import gcd_uart_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       frame_end,
    output logic       txd
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             baud_last;
    logic             load;

    assign baud_last = (baud_cnt == BAUD_MAX);
    assign load      = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (byte_valid) state_next = TX_START;
            TX_START: if (baud_last) state_next = TX_DATA;
            TX_DATA:  if (baud_last && bit_cnt == 3'd7) state_next = TX_STOP;
            TX_STOP:  if (baud_last) state_next = byte_valid ? TX_START : TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd        = 1'b1;
        byte_ready = 1'b0;
        frame_end  = 1'b0;
        case (state)
            TX_IDLE:  byte_ready = 1'b1;
            TX_START: txd = 1'b0;
            TX_DATA:  txd = shreg[0];
            TX_STOP: begin
                byte_ready = baud_last;
                frame_end  = baud_last;
            end
            default:  txd = 1'b1;
        endcase
    end

    // Baud timing and LSB-first shifting; bit_cnt wraps to zero on leaving DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
        end else if (load) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= byte_data;
        end else if (state != TX_IDLE) begin
            if (baud_last) begin
                baud_cnt <= '0;
                if (state == TX_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_uart_reporter.sv
// Snapshots GCD operands/result on a send pulse and reports "GCD(aa,bb)=rr\r\n" over UART TX.
// Owns the snapshot, decimal conversion, character sequencing and busy/done signalling.
module gcd_uart_reporter
    import gcd_uart_reporter_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [31:0] gcd_a,
    input  logic [31:0] gcd_b,
    input  logic [31:0] gcd_result,
    output logic        uart_txd,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    rep_state_t  state;
    rep_state_t  state_next;
    operand_t    snap_a;
    operand_t    snap_b;
    operand_t    snap_r;
    logic [3:0]  char_idx;
    logic [7:0]  char_byte;
    logic [15:0] dig_a;
    logic [15:0] dig_b;
    logic [15:0] dig_r;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_end;
    logic        load;

    assign load  = byte_valid && byte_ready;
    assign dig_a = to_digits(snap_a);
    assign dig_b = to_digits(snap_b);
    assign dig_r = to_digits(snap_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for the last character's stop bit, since its handshake happens a frame earlier.
    always_comb begin
        state_next = state;
        case (state)
            REP_IDLE:   if (send) state_next = REP_SEND;
            REP_SEND:   if (load && char_idx == LAST_IDX) state_next = REP_DRAIN;
            REP_DRAIN:  if (frame_end) state_next = REP_FINISH;
            REP_FINISH: state_next = REP_IDLE;
            default:    state_next = REP_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (state == REP_SEND);
        busy       = (state == REP_SEND) || (state == REP_DRAIN);
        done       = (state == REP_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_a   <= '0;
            snap_b   <= '0;
            snap_r   <= '0;
            char_idx <= 4'd0;
        end else if (state == REP_IDLE && send) begin
            snap_a   <= snap_operand(gcd_a);
            snap_b   <= snap_operand(gcd_b);
            snap_r   <= snap_operand(gcd_result);
            char_idx <= 4'd0;
        end else if (load && char_idx != LAST_IDX) begin
            char_idx <= char_idx + 4'd1;
        end
    end

    always_comb begin
        char_byte = ASCII_LF;
        case (char_idx)
            4'd0:    char_byte = ASCII_G;
            4'd1:    char_byte = ASCII_C;
            4'd2:    char_byte = ASCII_D;
            4'd3:    char_byte = ASCII_LPAREN;
            4'd4:    char_byte = dig_a[15:8];
            4'd5:    char_byte = dig_a[7:0];
            4'd6:    char_byte = ASCII_COMMA;
            4'd7:    char_byte = dig_b[15:8];
            4'd8:    char_byte = dig_b[7:0];
            4'd9:    char_byte = ASCII_RPAREN;
            4'd10:   char_byte = ASCII_EQ;
            4'd11:   char_byte = dig_r[15:8];
            4'd12:   char_byte = dig_r[7:0];
            4'd13:   char_byte = ASCII_CR;
            default: char_byte = ASCII_LF;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (char_byte),
        .byte_ready(byte_ready),
        .frame_end (frame_end),
        .txd       (uart_txd)
    );

endmodule
